perf_mmio_ctrl: RTL

Sequencing controller for the performance-counter MMIO window. It sits between the data-memory port of the MEM stage and the counter bank (cache hit/miss, branch, misprediction and stall counters). It decodes accesses to the 0xFFC0–0xFFFF window and answers them with a one-wait-state handshake. It returns consistent 32-bit values over the 16-bit bus through a hi-word snapshot, issues one-cycle clear pulses, and maintains freeze and sticky-overflow state.

---
 rtl/perf_mmio_if.sv | 21 ++
 rtl/perf_mmio_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/perf_mmio_if.sv
// MEM-stage data port as seen by the perf-counter MMIO window.
// The master drives the requests and the slave returns hit, response strobe and read data.
interface perf_mmio_if;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        mmio_hit;
   logic        mmio_resp;
   logic [15:0] mmio_rdata;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata,
      input  mmio_hit, mmio_resp, mmio_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata,
      output mmio_hit, mmio_resp, mmio_rdata
   );
endinterface

// File: rtl/perf_mmio_ctrl.sv
// Performance-counter MMIO window: one-wait-state access, hi-word snapshot,
// clear pulses, freeze control and sticky overflow flags.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | waiting for a window hit; request captured on the hit edge
//   ST_ACK  | response/clear cycle; bus requests ignored
module perf_mmio_ctrl #(
   parameter int          NUM_CNT = 9,
   parameter logic [15:0] BASE    = 16'hFFC0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   perf_mmio_if.slave             bus,
   input  logic [NUM_CNT*32-1:0]  cnt_value,
   output logic [NUM_CNT-1:0]     cnt_clear,
   output logic                   cnt_enable
);

   typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

   state_t               state, state_n;
   logic                 resp_q, resp_n;
   logic [15:0]          rdata_q, rdata_n;
   logic [NUM_CNT-1:0]   clear_q, clear_n;
   logic                 freeze, freeze_n;
   logic [NUM_CNT-1:0]   ovf, ovf_n, ovf_set, ovf_clr;
   logic                 snap_valid, snap_valid_n;
   logic [3:0]           snap_idx, snap_idx_n;
   logic [15:0]          snap_hi, snap_hi_n;

   logic [15:0]          offset;
   logic [4:0]           k;
   logic [3:0]           idx;
   logic                 is_hi;
   logic                 is_cnt;
   logic [31:0]          sel;
   logic [NUM_CNT-1:0]   idx_mask;
   logic                 unused_ok;

   assign offset       = bus.mem_address - BASE;
   assign k            = bus.mem_address[5:1];
   assign idx          = k[4:1];
   assign is_hi        = k[0];
   assign is_cnt       = int'(idx) < NUM_CNT;
   assign bus.mmio_hit = (offset[15:6] == 10'd0) && (bus.mem_read || bus.mem_write);
   assign bus.mmio_resp  = resp_q;
   assign bus.mmio_rdata = rdata_q;
   assign cnt_clear    = clear_q;
   assign cnt_enable   = ~freeze;
   assign unused_ok    = ^{bus.mem_wdata[15:2], bus.mem_address[0], offset[5:0]};

   always_comb begin
      sel      = '0;
      idx_mask = '0;
      ovf_set  = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (int'(idx) == i) begin
            sel         = cnt_value[i*32 +: 32];
            idx_mask[i] = 1'b1;
         end
         ovf_set[i] = (cnt_value[i*32 +: 32] == 32'hFFFF_FFFF);
      end
   end

   always_comb begin
      state_n      = state;
      resp_n       = 1'b0;
      rdata_n      = '0;
      clear_n      = '0;
      freeze_n     = freeze;
      snap_valid_n = snap_valid;
      snap_idx_n   = snap_idx;
      snap_hi_n    = snap_hi;
      ovf_clr      = '0;
      case (state)
         ST_IDLE: begin
            if (bus.mmio_hit) begin
               state_n = ST_ACK;
               resp_n  = 1'b1;
               // a simultaneous read+write is handled as a write
               if (bus.mem_write) begin
                  if (is_cnt) begin
                     clear_n = idx_mask;
                     ovf_clr = idx_mask;
                     if (snap_idx == idx) snap_valid_n = 1'b0;
                  end else if (k == 5'd30) begin
                     freeze_n = bus.mem_wdata[0];
                     if (bus.mem_wdata[1]) begin
                        clear_n = '1;
                        ovf_clr = '1;
                     end
                  end
               end else begin
                  if (is_cnt && !is_hi) begin
                     rdata_n      = sel[15:0];
                     snap_hi_n    = sel[31:16];
                     snap_idx_n   = idx;
                     snap_valid_n = 1'b1;
                  end else if (is_cnt) begin
                     if (snap_valid && (snap_idx == idx)) begin
                        rdata_n      = snap_hi;
                        snap_valid_n = 1'b0;
                     end else begin
                        rdata_n = sel[31:16];
                     end
                  end else if (k == 5'd30) begin
                     rdata_n = {15'b0, freeze};
                  end else if (k == 5'd31) begin
                     rdata_n     = 16'(ovf);
                     rdata_n[15] = freeze;
                  end
               end
            end
         end
         ST_ACK:  state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      // clear has priority over a same-cycle overflow
      ovf_n = (ovf | ovf_set) & ~ovf_clr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
         clear_q    <= '0;
         freeze     <= 1'b0;
         ovf        <= '0;
         snap_valid <= 1'b0;
         snap_idx   <= '0;
         snap_hi    <= '0;
      end else begin
         state      <= state_n;
         resp_q     <= resp_n;
         rdata_q    <= rdata_n;
         clear_q    <= clear_n;
         freeze     <= freeze_n;
         ovf        <= ovf_n;
         snap_valid <= snap_valid_n;
         snap_idx   <= snap_idx_n;
         snap_hi    <= snap_hi_n;
      end
   end

endmodule
